text_line_ctrl: RTL

//  Owns the 11-slot character line drawn by the VGA ASCII renderer and sequences every change to it.
//  Two requesters share the line through a round-robin arbiter: requester 0 is keypad/input, requester 1 is the result engine.

---
 rtl/text_pkg.sv | 25 ++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/text_line_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared types and constants for the character-line controller.
// Command encoding, line size and the glyph range the font can draw.
package text_pkg;

    typedef enum logic [1:0] {
        CMD_APPEND    = 2'b00,
        CMD_BACKSPACE = 2'b01,
        CMD_CLEAR     = 2'b10,
        CMD_RSVD      = 2'b11
    } cmd_e;

    localparam int          NUM_CHARS_DEF = 11;
    localparam logic [7:0]  CHAR_BLANK    = 8'd0;
    localparam logic [7:0]  DIGIT_LO      = 8'd48;
    localparam logic [7:0]  DIGIT_HI      = 8'd57;
    localparam logic [7:0]  UPPER_LO      = 8'd65;
    localparam logic [7:0]  UPPER_HI      = 8'd90;

    // Digits and upper-case letters are the only codes the font holds.
    function automatic logic is_glyph(input logic [7:0] code);
        return ((code >= DIGIT_LO) && (code <= DIGIT_HI)) ||
               ((code >= UPPER_LO) && (code <= UPPER_HI));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: one-hot grant only while en_i is high.
// Pointer moves to the non-winning requester after every grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
            else                gnt_o = req_i;
        end
        ptr_d = ptr_q;
        if (gnt_o[0])      ptr_d = 1'b1;
        else if (gnt_o[1]) ptr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/text_line_ctrl.sv
// Character-line owner: arbitrates edits into a shadow line, commits it to the display on vblank.
// Optional cursor blink overlay when CURSOR_BLINK_EN is defined.
module text_line_ctrl
    import text_pkg::*;
#(
    parameter int NUM_CHARS = NUM_CHARS_DEF
`ifdef CURSOR_BLINK_EN
  , parameter int          BLINK_FRAMES = 30
  , parameter logic [7:0]  CURSOR_CHAR  = 8'd73
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vblank_i,
    input  logic [1:0]                req_valid_i,
    input  logic [1:0][1:0]           req_cmd_i,
    input  logic [1:0][7:0]           req_char_i,
    output logic [1:0]                req_ready_o,
    output logic [NUM_CHARS-1:0][7:0] character_o,
    output logic [3:0]                count_o,
    output logic                      full_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [3:0] FULL_CNT = 4'(NUM_CHARS);

    logic [1:0]                state_q, state_d;
    cmd_e                      cmd_q, cmd_d;
    logic [7:0]                char_q, char_d;
    logic [NUM_CHARS-1:0][7:0] shadow_q, shadow_d;
    logic [NUM_CHARS-1:0][7:0] disp_q;
    logic [3:0]                count_q, count_d;
    logic [3:0]                idx_q, idx_d;
    logic [1:0]                gnt;
    logic                      err;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_valid_i),
        .en_i  ((state_q == ST_IDLE) && !rst),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        char_d   = char_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        idx_d    = idx_q;
        err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    cmd_d   = cmd_e'(gnt[1] ? req_cmd_i[1] : req_cmd_i[0]);
                    char_d  = gnt[1] ? req_char_i[1] : req_char_i[0];
                    idx_d   = FULL_CNT - 4'd1;
                    state_d = (cmd_d == CMD_CLEAR) ? ST_CLEAR : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (cmd_q)
                    CMD_APPEND: begin
                        if ((count_q < FULL_CNT) && is_glyph(char_q)) begin
                            shadow_d[count_q] = char_q;
                            count_d           = count_q + 4'd1;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    CMD_BACKSPACE: begin
                        if (count_q != 4'd0) begin
                            shadow_d[count_q - 4'd1] = CHAR_BLANK;
                            count_d                  = count_q - 4'd1;
                        end
                    end
                    default: err = 1'b1;
                endcase
            end
            ST_CLEAR: begin
                // Sweep right to left; count drops only once the last slot is blank.
                shadow_d[idx_q] = CHAR_BLANK;
                if (idx_q == 4'd0) begin
                    count_d = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= CMD_APPEND;
            char_q   <= CHAR_BLANK;
            shadow_q <= '0;
            disp_q   <= '0;
            count_q  <= 4'd0;
            idx_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            char_q   <= char_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            if (vblank_i && (state_q != ST_CLEAR)) disp_q <= shadow_q;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;
    logic [3:0]    disp_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            disp_cnt_q  <= 4'd0;
        end else if (vblank_i) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            if (state_q != ST_CLEAR) disp_cnt_q <= count_q;
        end
    end

    always_comb begin
        character_o = disp_q;
        if (phase_q && (disp_cnt_q < FULL_CNT)) character_o[disp_cnt_q] = CURSOR_CHAR;
    end
`else
    assign character_o = disp_q;
`endif

    assign req_ready_o = gnt;
    assign count_o     = count_q;
    assign full_o      = (count_q == FULL_CNT);
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err;

endmodule
